// File: rtl/wb_pkg.sv
// Shared widths and types for the write-back controller and its buffer.
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DEPTH      = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Write buffer with two ordered push ports, one pop port and every slot visible for hazard scans.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int DEPTH = wb_pkg::DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push0,
    input  logic [REG_ADDR_W-1:0] push0_rd,
    input  logic [XLEN-1:0]       push0_data,
    input  logic                  push1,
    input  logic [REG_ADDR_W-1:0] push1_rd,
    input  logic [XLEN-1:0]       push1_data,
    input  logic                  pop,
    output logic [REG_ADDR_W-1:0] head_rd,
    output logic [XLEN-1:0]       head_data,
    output logic [CW-1:0]         count,
    output logic [PW-1:0]         rd_ptr,
    output logic [REG_ADDR_W-1:0] slot_rd [DEPTH],
    output logic [XLEN-1:0]       slot_data [DEPTH]
);
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr1;

    // push1 lands behind push0 when both are accepted in the same cycle
    assign wr_ptr1 = wr_ptr + PW'(push0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_rd[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            if (push0) begin
                slot_rd[wr_ptr]   <= push0_rd;
                slot_data[wr_ptr] <= push0_data;
            end
            if (push1) begin
                slot_rd[wr_ptr1]   <= push1_rd;
                slot_data[wr_ptr1] <= push1_data;
            end
            wr_ptr <= wr_ptr + PW'(push0) + PW'(push1);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign head_rd   = (count != '0) ? slot_rd[rd_ptr]   : '0;
    assign head_data = (count != '0) ? slot_data[rd_ptr] : '0;
endmodule

// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates load/ALU writes into a buffer, drains one
// register-file write per cycle and reports hazards with youngest-entry forwarding.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int XLEN  = wb_pkg::XLEN,
    parameter int DEPTH = wb_pkg::DEPTH,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  W_en,
    output logic [REG_ADDR_W-1:0] Rd,
    output logic [XLEN-1:0]       Wr_data,
    input  logic [REG_ADDR_W-1:0] Rs1,
    input  logic [REG_ADDR_W-1:0] Rs2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic [XLEN-1:0]       fwd1_data,
    output logic [XLEN-1:0]       fwd2_data,
    output logic [CW-1:0]         count,
    output logic                  empty
);
    logic                  ld_push, alu_push;
    logic [PW-1:0]         rd_ptr;
    logic [REG_ADDR_W-1:0] slot_rd [DEPTH];
    logic [XLEN-1:0]       slot_data [DEPTH];
    logic [PW-1:0]         idx;

    // Readiness looks only at the registered count; load keeps the last free slot.
    assign ld_ready  = rst_n && (count < CW'(DEPTH));
    assign alu_ready = rst_n && (count < CW'(DEPTH)) &&
                       !(ld_valid && (count >= CW'(DEPTH - 1)));

    assign ld_push  = ld_valid  && ld_ready  && (ld_rd  != '0);
    assign alu_push = alu_valid && alu_ready && (alu_rd != '0);

    assign empty = (count == '0);
    assign W_en  = !empty;

    wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push0      (ld_push),
        .push0_rd   (ld_rd),
        .push0_data (ld_data),
        .push1      (alu_push),
        .push1_rd   (alu_rd),
        .push1_data (alu_data),
        .pop        (W_en),
        .head_rd    (Rd),
        .head_data  (Wr_data),
        .count      (count),
        .rd_ptr     (rd_ptr),
        .slot_rd    (slot_rd),
        .slot_data  (slot_data)
    );

    // Walk entries oldest to youngest so the last match is the youngest one.
    always_comb begin
        hazard1   = 1'b0;
        hazard2   = 1'b0;
        fwd1_data = '0;
        fwd2_data = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                if (Rs1 != '0 && slot_rd[idx] == Rs1) begin
                    hazard1   = 1'b1;
                    fwd1_data = slot_data[idx];
                end
                if (Rs2 != '0 && slot_rd[idx] == Rs2) begin
                    hazard2   = 1'b1;
                    fwd2_data = slot_data[idx];
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: directed scenarios plus random traffic against a queue model.
module tb_wb_ctrl;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ld_valid = 1'b0, alu_valid = 1'b0;
    logic            ld_ready, alu_ready;
    logic [4:0]      ld_rd = '0, alu_rd = '0;
    logic [XLEN-1:0] ld_data = '0, alu_data = '0;
    logic            W_en;
    logic [4:0]      Rd;
    logic [XLEN-1:0] Wr_data;
    logic [4:0]      Rs1 = '0, Rs2 = '0;
    logic            hazard1, hazard2;
    logic [XLEN-1:0] fwd1_data, fwd2_data;
    logic [CW-1:0]   count;
    logic            empty;

    logic [XLEN+4:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    wb_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .W_en(W_en), .Rd(Rd), .Wr_data(Wr_data),
        .Rs1(Rs1), .Rs2(Rs2),
        .hazard1(hazard1), .hazard2(hazard2),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
        .count(count), .empty(empty)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Youngest queued entry for rs: {hit, data}
    function automatic logic [XLEN:0] model_fwd(input logic [4:0] rs);
        logic [XLEN:0] r;
        r = '0;
        if (rs != 0)
            for (int i = 0; i < exp_q.size(); i++)
                if (exp_q[i][XLEN+4:XLEN] == rs) r = {1'b1, exp_q[i][XLEN-1:0]};
        return r;
    endfunction

    task automatic set_in(input logic lv, input logic [4:0] lr, input logic [XLEN-1:0] ldat,
                          input logic av, input logic [4:0] ar, input logic [XLEN-1:0] adat);
        ld_valid = lv; ld_rd = lr; ld_data = ldat;
        alu_valid = av; alu_rd = ar; alu_data = adat;
    endtask

    // Check all outputs against the model, then advance model and DUT one edge.
    task automatic step();
        int sz;
        logic exp_ld_rdy, exp_alu_rdy;
        logic [XLEN:0] f1, f2;
        #1;
        sz = exp_q.size();
        exp_ld_rdy  = (sz < DEPTH);
        exp_alu_rdy = (sz < DEPTH) && !(ld_valid && sz >= DEPTH - 1);
        chk("count", 64'(count), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("w_en", 64'(W_en), 64'(sz != 0));
        if (sz != 0) begin
            chk("rd", 64'(Rd), 64'(exp_q[0][XLEN+4:XLEN]));
            chk("wr_data", 64'(Wr_data), 64'(exp_q[0][XLEN-1:0]));
        end else begin
            chk("rd_idle", 64'(Rd), 64'(0));
            chk("wr_data_idle", 64'(Wr_data), 64'(0));
        end
        chk("ld_ready", 64'(ld_ready), 64'(exp_ld_rdy));
        chk("alu_ready", 64'(alu_ready), 64'(exp_alu_rdy));
        f1 = model_fwd(Rs1);
        f2 = model_fwd(Rs2);
        chk("hazard1", 64'(hazard1), 64'(f1[XLEN]));
        chk("hazard2", 64'(hazard2), 64'(f2[XLEN]));
        chk("fwd1", 64'(fwd1_data), 64'(f1[XLEN-1:0]));
        chk("fwd2", 64'(fwd2_data), 64'(f2[XLEN-1:0]));
        if (sz != 0) void'(exp_q.pop_front());
        if (ld_valid && exp_ld_rdy && ld_rd != 0) exp_q.push_back({ld_rd, ld_data});
        if (alu_valid && exp_alu_rdy && alu_rd != 0) exp_q.push_back({alu_rd, alu_data});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        set_in(0, 0, 0, 0, 0, 0);
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_done", 64'(exp_q.size()), 64'(0));
        step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wen"}, 64'(W_en), 64'(0));
        chk({tag, "_rd"}, 64'(Rd), 64'(0));
        chk({tag, "_data"}, 64'(Wr_data), 64'(0));
        chk({tag, "_count"}, 64'(count), 64'(0));
        chk({tag, "_empty"}, 64'(empty), 64'(1));
        chk({tag, "_ld_rdy"}, 64'(ld_ready), 64'(0));
        chk({tag, "_alu_rdy"}, 64'(alu_ready), 64'(0));
        chk({tag, "_hz"}, 64'({hazard1, hazard2}), 64'(0));
        chk({tag, "_fwd"}, 64'({fwd1_data, fwd2_data}), 64'(0));
    endtask

    initial begin
        // reset state
        repeat (2) @(negedge clk);
        Rs1 = 5'd1; Rs2 = 5'd2;
        set_in(1, 1, 32'h1, 1, 2, 32'h2);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // single load
        set_in(1, 5'd1, 32'hA5A5A5A5, 0, 0, 0);
        step();
        drain(8);

        // simultaneous load and ALU: x2 then x3
        set_in(1, 5'd2, 32'h5A5A5A5A, 1, 5'd3, 32'h00000011);
        step();
        drain(8);

        // x0 drop
        set_in(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        step();

        // full: both ports every cycle for 6 cycles
        for (int i = 0; i < 6; i++) begin
            set_in(1, 5'(4 + 2 * i), 32'h100 + 32'(i), 1, 5'(5 + 2 * i), 32'h200 + 32'(i));
            step();
        end
        drain(12);

        // forwarding: youngest rd=5 entry wins
        Rs1 = 5'd5; Rs2 = 5'd0;
        set_in(1, 5'd5, 32'h1, 1, 5'd5, 32'h2);
        step();
        chk("fwd_dir_hz1", 64'(hazard1), 64'(1));
        chk("fwd_dir_data1", 64'(fwd1_data), 64'(2));
        chk("fwd_dir_hz2", 64'(hazard2), 64'(0));
        drain(8);

        // reset mid-operation with 3 entries queued
        set_in(1, 5'd6, 32'hA, 1, 5'd7, 32'hB);
        step();
        set_in(1, 5'd8, 32'hC, 1, 5'd9, 32'hD);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        Rs1 = 5'd8; Rs2 = 5'd9;
        #1;
        chk("pre_reset_count", 64'(count), 64'(3));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step();

        // random traffic
        for (int i = 0; i < 300; i++) begin
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            Rs1 = 5'($urandom_range(0, 7));
            Rs2 = 5'($urandom_range(0, 7));
            step();
        end
        drain(12);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
